fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage of the CPU. It owns the program counter and drives the 8-bit fetch address into the combinational instruction memory. It captures the returned 16-bit opcode into the IF/ID pipeline register for the decoder. It resolves unconditional JMP itself by predecoding, with no bubble, and accepts stall and redirect requests (taken JNZ, JMPR) from later stages.

## Interface
- `PC_W`, default 8: program-counter and instruction-address width.
- `OP_W`, default 16: instruction width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  PC_W  fetch address to instruction memory (equals the PC register).
- `op`  in  OP_W  instruction returned combinationally for `pc`, same cycle.
- `stall_i`  in  1  decode/execute cannot accept; hold the stage.
- `redirect_i`  in  1  later stage took a control transfer (JNZ taken, JMPR).
- `redirect_pc_i`  in  PC_W  target of that transfer.
- `if_op`  out  OP_W  captured instruction to decode.
- `if_pc`  out  PC_W  address of `if_op`; decode forms the JMP link value as `if_pc + 1`.
- `if_valid`  out  1  `if_op` is a real instruction, not a bubble.
- `halted`  out  1  a JMP to its own address was fetched; the core is parked.

## Operation
- State: `pc_q`, `ir_q`, `ir_pc_q`, `ir_valid_q`, `halted_q`. Outputs drive directly from these registers.
- Per-cycle priority, highest first:
  1. **Redirect** (`redirect_i`=1, `stall_i` ignored):
     - `pc_q` <= `redirect_pc_i`, `ir_valid_q` <= 0 (flush).
     - `ir_q`/`ir_pc_q` are don't-care.
     - `halted_q` <= 0.
  2. **Stall**: all registers hold. `pc` stays stable, so `op` stays stable.
  3. **Advance**:
     - `ir_q` <= `op`, `ir_pc_q` <= `pc_q`, `ir_valid_q` <= 1.
     - `pc_q` <= `op[11:4]` if `op[15:12]` == JMP, else `pc_q + 1`.
- PC increment is modulo 2^PC_W: 255 wraps to 0 with no flag.
- JMP predecode uses only the opcode field. The link-register field `op[3:0]` passes through untouched in `if_op`. Decode still performs the link write.
- JNZ, JMPR and all other opcodes advance sequentially. Their redirect arrives later via `redirect_i`.
- Halt:
  - On Advance with a JMP whose target equals `pc_q`, `halted_q` <= 1.
  - `halted_q` is sticky until reset or redirect.
  - Fetch continues re-fetching the same JMP, so `if_valid` stays 1 and behaviour stays self-consistent.
- Opcode values come from the shared definitions. The stage never interprets any field other than `op[15:12]` and `op[11:4]`.
- Fetching an address the memory leaves undefined (X) is a program error. Behaviour is unspecified, and the bench must not do it.

## Timing
- Reset (async assert, sync-safe deassert to the clock):
  - `pc`=0, `if_op`=16'h0000, `if_pc`=0, `if_valid`=0, `halted`=0.
- The first valid instruction appears at `if_*` one edge after reset release.
- Fetch latency: the `pc` to `op` path is combinational. `if_op` is registered, 1 cycle after `pc`.
- Sequential throughput: 1 instruction per cycle.
- JMP costs 0 bubbles: the instruction after JMP at `if_*` is the target.
- Redirect costs exactly 1 bubble cycle at `if_*` (`if_valid`=0). Squashing older in-flight instructions is downstream's job.
- Redirect and stall in the same cycle: the redirect wins.
- Redirect while `if_valid`=0: same behaviour.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately. The stall/redirect is discarded.

## Structure
- Opcode constants (LI, ADD, ADDI, LOAD, STORE, CMP, CMPI, JMP, JNZ, JMPR) stay in the shared `def.h`.
- Add to `def.h`:
  - the PC width;
  - field-position constants for opcode `[15:12]` and immediate/target `[11:4]`.
- No sub-module. The next-PC mux and predecode are a few lines inside `fetch_stage`.

## Test plan
- **Reset and sequential fetch:** release reset with the standard program loaded → `pc` 0,1,2,3 on successive cycles; `if_pc` 0,1,2 with `if_valid`=1 from the first edge; `if_op` at 0 = {LI,5,0}.
- **JMP with zero bubbles:** at `pc`=8 ({JMP,20,e}) → next `pc`=20; `if_pc` sequence 8,20,21 with `if_valid` never 0.
- **Stall:** hold `stall_i`=1 for 3 cycles at `pc`=5 → `pc`, `if_op` and `if_pc` remain constant; resume gives `pc`=6 on the first free cycle.
- **Redirect with stall:** `redirect_i`=1, `redirect_pc_i`=4 and `stall_i`=1 at `pc`=7 → next `pc`=4, `if_valid`=0 for one cycle, then `if_pc`=4 valid.
- **Halt detection:** fetch {JMP,9,f} at 9 → `halted`=1 one cycle later and stays 1; a redirect to 0 clears it; async reset mid-stall returns all outputs to reset values.
- **Wrap-around:** a model memory with no JMP at 254 and 255 → `pc` goes 255 then 0; `if_pc` goes 255 then 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: opcode encodings, PC/instruction widths and the
// instruction field positions the fetch stage predecodes.
package fetch_stage_pkg;

    localparam int PC_WIDTH = 8;
    localparam int OP_WIDTH = 16;

    // Opcode lives in [15:12]; immediate / jump target in [11:4]; link reg in [3:0].
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 4;

    typedef enum logic [3:0] {
        OPC_LI    = 4'h1,
        OPC_ADD   = 4'h2,
        OPC_ADDI  = 4'h3,
        OPC_LOAD  = 4'h4,
        OPC_STORE = 4'h5,
        OPC_CMP   = 4'h6,
        OPC_CMPI  = 4'h7,
        OPC_JMP   = 4'h8,
        OPC_JNZ   = 4'h9,
        OPC_JMPR  = 4'hA
    } opcode_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, control inputs from later
// stages and the IF/ID pipeline register outputs.
interface fetch_stage_if #(
    parameter int PC_W = 8,
    parameter int OP_W = 16
);
    logic [PC_W-1:0] pc;
    logic [OP_W-1:0] op;
    logic            stall_i;
    logic            redirect_i;
    logic [PC_W-1:0] redirect_pc_i;
    logic [OP_W-1:0] if_op;
    logic [PC_W-1:0] if_pc;
    logic            if_valid;
    logic            halted;

    // if_valid marks if_op/if_pc as a real instruction. stall_i holds every
    // register (pc and therefore op stay stable); redirect_i overrides stall_i,
    // loads redirect_pc_i and produces exactly one if_valid=0 bubble.
    modport master (
        output pc, if_op, if_pc, if_valid, halted,
        input  op, stall_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  pc, if_op, if_pc, if_valid, halted,
        output op, stall_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, registers the fetched opcode into IF/ID,
// folds unconditional JMP with no bubble and detects a self-jump halt.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = PC_WIDTH,
    parameter int OP_W = OP_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_stage_if.master  bus
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [OP_W-1:0] ir_q, ir_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic            ir_valid_q, ir_valid_d;
    logic            halted_q, halted_d;

    logic            is_jmp;
    logic [PC_W-1:0] jmp_tgt;

    assign is_jmp  = (bus.op[OPC_MSB:OPC_LSB] == OPC_JMP);
    assign jmp_tgt = PC_W'(bus.op[TGT_MSB:TGT_LSB]);

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        if (bus.redirect_i) begin
            pc_d       = bus.redirect_pc_i;
            ir_valid_d = 1'b0;
            halted_d   = 1'b0;
        end else if (!bus.stall_i) begin
            ir_d       = bus.op;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = is_jmp ? jmp_tgt : pc_q + PC_W'(1);
            // A jump to itself never makes progress: park the core.
            if (is_jmp && (jmp_tgt == pc_q)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.if_op    = ir_q;
    assign bus.if_pc    = ir_pc_q;
    assign bus.if_valid = ir_valid_q;
    assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, JMP folding, stall,
// redirect, halt and PC wrap-around against a small program memory.
module tb_fetch_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [15:0] mem [256];

    fetch_stage_if #(.PC_W(8), .OP_W(16)) bus_if ();

    fetch_stage #(.PC_W(8), .OP_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    assign bus_if.op = mem[bus_if.pc];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic stall, input logic redir, input logic [7:0] rpc);
        bus_if.stall_i       = stall;
        bus_if.redirect_i    = redir;
        bus_if.redirect_pc_i = rpc;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h2000 | 16'(i << 4);     // ADD filler, never a JMP
        end
        mem[0] = 16'h1050;                       // {LI,5,0}
        mem[7] = 16'h9020;                       // {JNZ,2,0}: sequential at fetch
        mem[8] = 16'h814E;                       // {JMP,20,e}
        mem[9] = 16'h809F;                       // {JMP,9,f}: self-jump
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'd0);
        step(); step();
        checks++; if (bus_if.pc !== 8'd0) begin errors++; $display("FAIL rst_pc: got %0d want 0", bus_if.pc); end
        checks++; if (bus_if.if_op !== 16'h0000) begin errors++; $display("FAIL rst_if_op: got %h want 0000", bus_if.if_op); end
        checks++; if (bus_if.if_pc !== 8'd0) begin errors++; $display("FAIL rst_if_pc: got %0d want 0", bus_if.if_pc); end
        checks++; if (bus_if.if_valid !== 1'b0) begin errors++; $display("FAIL rst_if_valid: got %b want 0", bus_if.if_valid); end
        checks++; if (bus_if.halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", bus_if.halted); end
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        step();
        checks++; if (bus_if.pc !== 8'd1) begin errors++; $display("FAIL seq_pc1: got %0d want 1", bus_if.pc); end
        checks++; if (bus_if.if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid0: got %b want 1", bus_if.if_valid); end
        checks++; if (bus_if.if_pc !== 8'd0) begin errors++; $display("FAIL seq_if_pc0: got %0d want 0", bus_if.if_pc); end
        checks++; if (bus_if.if_op !== 16'h1050) begin errors++; $display("FAIL seq_if_op0: got %h want 1050", bus_if.if_op); end
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++; if (bus_if.pc !== 8'(k + 1)) begin errors++; $display("FAIL seq_pc: got %0d want %0d", bus_if.pc, k + 1); end
            checks++; if (bus_if.if_pc !== 8'(k) || bus_if.if_valid !== 1'b1) begin
                errors++; $display("FAIL seq_if_pc: got %0d/%b want %0d/1", bus_if.if_pc, bus_if.if_valid, k);
            end
        end
    endtask

    task automatic test_jmp();
        drive(1'b0, 1'b1, 8'd8);
        step();
        drive(1'b0, 1'b0, 8'd0);
        checks++; if (bus_if.pc !== 8'd8 || bus_if.if_valid !== 1'b0) begin
            errors++; $display("FAIL jmp_setup: got pc %0d valid %b want 8/0", bus_if.pc, bus_if.if_valid);
        end
        step();
        checks++; if (bus_if.pc !== 8'd20) begin errors++; $display("FAIL jmp_target_pc: got %0d want 20", bus_if.pc); end
        checks++; if (bus_if.if_pc !== 8'd8 || bus_if.if_valid !== 1'b1) begin
            errors++; $display("FAIL jmp_if_pc8: got %0d/%b want 8/1", bus_if.if_pc, bus_if.if_valid);
        end
        checks++; if (bus_if.if_op !== 16'h814E) begin errors++; $display("FAIL jmp_if_op: got %h want 814e", bus_if.if_op); end
        step();
        checks++; if (bus_if.if_pc !== 8'd20 || bus_if.if_valid !== 1'b1) begin
            errors++; $display("FAIL jmp_if_pc20: got %0d/%b want 20/1", bus_if.if_pc, bus_if.if_valid);
        end
        step();
        checks++; if (bus_if.if_pc !== 8'd21 || bus_if.if_valid !== 1'b1 || bus_if.pc !== 8'd22) begin
            errors++; $display("FAIL jmp_if_pc21: got if_pc %0d valid %b pc %0d want 21/1/22", bus_if.if_pc, bus_if.if_valid, bus_if.pc);
        end
        checks++; if (bus_if.halted !== 1'b0) begin errors++; $display("FAIL jmp_no_halt: got %b want 0", bus_if.halted); end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 8'd4);
        step();
        drive(1'b0, 1'b0, 8'd0);
        step();
        checks++; if (bus_if.pc !== 8'd5 || bus_if.if_pc !== 8'd4) begin
            errors++; $display("FAIL stall_setup: got pc %0d if_pc %0d want 5/4", bus_if.pc, bus_if.if_pc);
        end
        drive(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus_if.pc !== 8'd5 || bus_if.if_pc !== 8'd4 || bus_if.if_op !== 16'h2040 || bus_if.if_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold: got pc %0d if_pc %0d if_op %h valid %b want 5/4/2040/1",
                                   bus_if.pc, bus_if.if_pc, bus_if.if_op, bus_if.if_valid);
            end
        end
        drive(1'b0, 1'b0, 8'd0);
        step();
        checks++; if (bus_if.pc !== 8'd6 || bus_if.if_pc !== 8'd5) begin
            errors++; $display("FAIL stall_resume: got pc %0d if_pc %0d want 6/5", bus_if.pc, bus_if.if_pc);
        end
    endtask

    task automatic test_redirect_stall();
        step();
        checks++; if (bus_if.pc !== 8'd7) begin errors++; $display("FAIL rs_setup: got pc %0d want 7", bus_if.pc); end
        drive(1'b1, 1'b1, 8'd4);
        step();
        drive(1'b0, 1'b0, 8'd0);
        checks++; if (bus_if.pc !== 8'd4 || bus_if.if_valid !== 1'b0) begin
            errors++; $display("FAIL rs_bubble: got pc %0d valid %b want 4/0", bus_if.pc, bus_if.if_valid);
        end
        step();
        checks++; if (bus_if.if_pc !== 8'd4 || bus_if.if_valid !== 1'b1 || bus_if.pc !== 8'd5) begin
            errors++; $display("FAIL rs_after: got if_pc %0d valid %b pc %0d want 4/1/5", bus_if.if_pc, bus_if.if_valid, bus_if.pc);
        end
    endtask

    task automatic test_jnz_sequential();
        drive(1'b0, 1'b1, 8'd7);
        step();
        drive(1'b0, 1'b0, 8'd0);
        step();
        checks++; if (bus_if.pc !== 8'd8 || bus_if.if_op !== 16'h9020) begin
            errors++; $display("FAIL jnz_seq: got pc %0d if_op %h want 8/9020", bus_if.pc, bus_if.if_op);
        end
    endtask

    task automatic test_halt();
        drive(1'b0, 1'b1, 8'd9);
        step();
        drive(1'b0, 1'b0, 8'd0);
        checks++; if (bus_if.halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", bus_if.halted); end
        step();
        checks++; if (bus_if.halted !== 1'b1 || bus_if.pc !== 8'd9 || bus_if.if_pc !== 8'd9) begin
            errors++; $display("FAIL halt_set: got halted %b pc %0d if_pc %0d want 1/9/9", bus_if.halted, bus_if.pc, bus_if.if_pc);
        end
        step();
        checks++; if (bus_if.halted !== 1'b1 || bus_if.if_valid !== 1'b1 || bus_if.if_op !== 16'h809F) begin
            errors++; $display("FAIL halt_sticky: got halted %b valid %b if_op %h want 1/1/809f", bus_if.halted, bus_if.if_valid, bus_if.if_op);
        end
        drive(1'b0, 1'b1, 8'd0);
        step();
        drive(1'b0, 1'b0, 8'd0);
        checks++; if (bus_if.halted !== 1'b0 || bus_if.pc !== 8'd0 || bus_if.if_valid !== 1'b0) begin
            errors++; $display("FAIL halt_clear: got halted %b pc %0d valid %b want 0/0/0", bus_if.halted, bus_if.pc, bus_if.if_valid);
        end
        // Re-enter halt, then hit async reset while stalled.
        drive(1'b0, 1'b1, 8'd9);
        step();
        drive(1'b0, 1'b0, 8'd0);
        step();
        drive(1'b1, 1'b0, 8'd0);
        step();
        checks++; if (bus_if.halted !== 1'b1) begin errors++; $display("FAIL halt_reenter: got %b want 1", bus_if.halted); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus_if.pc !== 8'd0 || bus_if.if_op !== 16'h0000 || bus_if.if_pc !== 8'd0 ||
                      bus_if.if_valid !== 1'b0 || bus_if.halted !== 1'b0) begin
            errors++; $display("FAIL async_rst: got pc %0d if_op %h if_pc %0d valid %b halted %b want 0/0000/0/0/0",
                               bus_if.pc, bus_if.if_op, bus_if.if_pc, bus_if.if_valid, bus_if.halted);
        end
        step();
        drive(1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        step();
        checks++; if (bus_if.pc !== 8'd1 || bus_if.if_op !== 16'h1050 || bus_if.if_valid !== 1'b1) begin
            errors++; $display("FAIL rst_restart: got pc %0d if_op %h valid %b want 1/1050/1", bus_if.pc, bus_if.if_op, bus_if.if_valid);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 8'd254);
        step();
        drive(1'b0, 1'b0, 8'd0);
        step();
        checks++; if (bus_if.pc !== 8'd255 || bus_if.if_pc !== 8'd254) begin
            errors++; $display("FAIL wrap_255: got pc %0d if_pc %0d want 255/254", bus_if.pc, bus_if.if_pc);
        end
        step();
        checks++; if (bus_if.pc !== 8'd0 || bus_if.if_pc !== 8'd255) begin
            errors++; $display("FAIL wrap_0: got pc %0d if_pc %0d want 0/255", bus_if.pc, bus_if.if_pc);
        end
        step();
        checks++; if (bus_if.pc !== 8'd1 || bus_if.if_pc !== 8'd0 || bus_if.if_op !== 16'h1050) begin
            errors++; $display("FAIL wrap_after: got pc %0d if_pc %0d if_op %h want 1/0/1050", bus_if.pc, bus_if.if_pc, bus_if.if_op);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        load_program();
        test_reset();
        test_sequential();
        test_jmp();
        test_stall();
        test_redirect_stall();
        test_jnz_sequential();
        test_halt();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
